sim_mem_sequencer: RTL and testbench

//  Phase controller for the RISC-V simulation environment. Streams the program into

---
 rtl/sim_mem_sequencer.sv | 162 ++++++++++++++++
 tb/tb_sim_mem_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sim_mem_sequencer.sv
// Phase controller for the RISC-V simulation bench: load program, run datapath, dump data memory.
// Optional macro SIM_SEQ_HALT_DETECT_EN adds self-loop halt detection during RUN.
module sim_mem_sequencer #(
  parameter int             AW          = 32,
  parameter int             DW          = 32,
  parameter logic [AW-1:0]  DUMP_BASE   = AW'(32'h1001_0000),
  parameter int             DUMP_WORDS  = 256,
  parameter int             MAX_RUN     = 100000,
  parameter int             HALT_STABLE = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stim_valid,
  input  logic [DW-1:0] stim_data,
  input  logic          stim_eof,
  output logic          stim_ready,
  output logic          imem_wr_n,
  output logic [AW-1:0] imem_addr,
  output logic [DW-1:0] imem_wdata,
  output logic          dut_rst,
  input  logic [AW-1:0] dut_pc,
  input  logic          dut_rd,
  input  logic          dut_wr,
  input  logic [AW-1:0] dut_addr,
  input  logic [DW-1:0] dut_wdata,
  output logic          dmem_rd,
  output logic          dmem_wr_n,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  output logic          sink_en,
  output logic [DW-1:0] sink_data,
  output logic [2:0]    phase,
  output logic          timeout,
  output logic          done
);

  localparam int RCW = $clog2(MAX_RUN + 1);
  localparam int DCW = $clog2(DUMP_WORDS + 1);
  localparam logic [RCW-1:0] RUN_LAST = RCW'(MAX_RUN - 1);
  localparam logic [DCW-1:0] DUMP_CNT = DCW'(DUMP_WORDS);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    DUMP = 3'd3,
    DONE = 3'd4
  } phase_t;

  phase_t         state, state_nxt;
  logic [AW-3:0]  wcnt;
  logic [AW-1:0]  prog_end;
  logic [RCW-1:0] rcnt;
  logic [DCW-1:0] dcnt;
  logic           vld_p1;
  logic           load_wr, run_pc_end, run_limit, run_halt, run_end;
  logic           dump_issue, dump_last;

  assign prog_end   = {wcnt, 2'b00};
  assign load_wr    = (state == LOAD) && stim_valid && !stim_eof;
  assign run_pc_end = dut_pc >= prog_end;
  assign run_limit  = rcnt == RUN_LAST;
  assign run_end    = (state == RUN) && (run_pc_end || run_limit || run_halt);
  assign dump_issue = (state == DUMP) && (dcnt != DUMP_CNT);
  assign dump_last  = (state == DUMP) && (dcnt == DUMP_CNT) && vld_p1;

`ifdef SIM_SEQ_HALT_DETECT_EN
  localparam int HCW = $clog2(HALT_STABLE + 1);
  logic [AW-1:0]  pc_prev;
  logic [HCW-1:0] hcnt, hcnt_nxt;

  // hcnt counts consecutive RUN cycles (including this one) spent at the same PC.
  assign hcnt_nxt = ((rcnt == '0) || (dut_pc != pc_prev)) ? HCW'(1) : hcnt + 1'b1;
  assign run_halt = hcnt_nxt >= HCW'(HALT_STABLE);

  always_ff @(posedge clk) begin
    if (!rst_n) hcnt <= '0;
    else if (state == RUN) hcnt <= hcnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (state == RUN) pc_prev <= dut_pc;
  end
`else
  assign run_halt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: if (stim_eof) state_nxt = (wcnt == '0) ? DUMP : RUN;
      RUN:  if (run_end) state_nxt = DUMP;
      DUMP: if (dump_last) state_nxt = DONE;
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stim_ready = 1'b0;
    imem_wr_n  = 1'b1;
    imem_addr  = '0;
    imem_wdata = '0;
    dut_rst    = 1'b1;
    dmem_rd    = 1'b0;
    dmem_wr_n  = 1'b1;
    dmem_addr  = '0;
    dmem_wdata = '0;
    case (state)
      LOAD: begin
        stim_ready = 1'b1;
        imem_wr_n  = !load_wr;
        imem_addr  = prog_end;
        imem_wdata = stim_data;
      end
      RUN: begin
        dut_rst    = 1'b0;
        imem_addr  = dut_pc;
        dmem_rd    = dut_rd;
        dmem_wr_n  = !dut_wr;
        dmem_addr  = dut_addr;
        dmem_wdata = dut_wdata;
      end
      DUMP: begin
        dmem_rd   = dump_issue;
        dmem_addr = DUMP_BASE + (AW'(dcnt) << 2);
      end
      default: ;
    endcase
  end

  assign sink_en   = vld_p1;
  assign sink_data = dmem_rdata;
  assign phase     = state;
  assign done      = state == DONE;

  // Stage p0 -> p1: a dump read issued now returns data next cycle, so the sink strobe lags by one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt    <= '0;
      rcnt    <= '0;
      dcnt    <= '0;
      vld_p1  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (load_wr) wcnt <= wcnt + 1'b1;
      if (state == RUN) rcnt <= rcnt + 1'b1;
      if (dump_issue) dcnt <= dcnt + 1'b1;
      vld_p1 <= dump_issue;
      if ((state == RUN) && run_limit && !run_pc_end && !run_halt) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sim_mem_sequencer.sv
// Directed self-checking bench for sim_mem_sequencer (default build, DUMP_WORDS=4, MAX_RUN=20).
module tb_sim_mem_sequencer;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic          clk = 1'b0;
  logic          rst_n, start, stim_valid, stim_eof;
  logic [DW-1:0] stim_data;
  logic          stim_ready, imem_wr_n, dut_rst;
  logic [AW-1:0] imem_addr, dut_pc, dut_addr, dmem_addr;
  logic [DW-1:0] imem_wdata, dut_wdata, dmem_wdata, dmem_rdata, sink_data;
  logic          dut_rd, dut_wr, dmem_rd, dmem_wr_n, sink_en, timeout, done;
  logic [2:0]    phase;

  logic [DW-1:0] mem [0:15];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sim_mem_sequencer #(
    .AW(AW), .DW(DW), .DUMP_BASE(BASE), .DUMP_WORDS(4), .MAX_RUN(20), .HALT_STABLE(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .stim_valid(stim_valid), .stim_data(stim_data), .stim_eof(stim_eof), .stim_ready(stim_ready),
    .imem_wr_n(imem_wr_n), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dut_rst(dut_rst), .dut_pc(dut_pc), .dut_rd(dut_rd), .dut_wr(dut_wr),
    .dut_addr(dut_addr), .dut_wdata(dut_wdata),
    .dmem_rd(dmem_rd), .dmem_wr_n(dmem_wr_n), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .sink_en(sink_en), .sink_data(sink_data), .phase(phase),
    .timeout(timeout), .done(done)
  );

  // Data memory: registered read, one-cycle latency.
  always @(posedge clk) begin
    if (!dmem_wr_n) mem[dmem_addr[5:2]] <= dmem_wdata;
    if (dmem_rd) dmem_rdata <= mem[dmem_addr[5:2]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n, sinks;
    logic [DW-1:0] exp_sink [0:3];
    rst_n = 1'b0; start = 1'b0; stim_valid = 1'b0; stim_eof = 1'b0; stim_data = '0;
    dut_pc = '0; dut_rd = 1'b0; dut_wr = 1'b0; dut_addr = '0; dut_wdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = DW'(i + 1);

    // Reset state
    do_reset();
    #1;
    chk("rst_phase", phase, 3'd0);
    chk("rst_dut_rst", dut_rst, 1'b1);
    chk("rst_imem_wr_n", imem_wr_n, 1'b1);
    chk("rst_dmem_rd", dmem_rd, 1'b0);
    chk("rst_dmem_wr_n", dmem_wr_n, 1'b1);
    chk("rst_sink_en", sink_en, 1'b0);
    chk("rst_stim_ready", stim_ready, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_done", done, 1'b0);

    // Test 1: 3-word program
    start = 1'b1; tick(); start = 1'b0;
    #1;
    chk("t1_phase_load", phase, 3'd1);
    chk("t1_stim_ready", stim_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      stim_valid = 1'b1; stim_data = 32'hA0 + k;
      #1;
      chk("t1_imem_wr_n", imem_wr_n, 1'b0);
      chk("t1_imem_addr", imem_addr, 4 * k);
      chk("t1_imem_wdata", imem_wdata, 32'hA0 + k);
      tick();
    end
    stim_eof = 1'b1;
    #1;
    chk("t1_eof_prio_no_wr", imem_wr_n, 1'b1);
    tick(); stim_eof = 1'b0; stim_valid = 1'b0;
    #1;
    chk("t1_phase_run", phase, 3'd2);
    chk("t1_dut_rst_low", dut_rst, 1'b0);
    dut_pc = 32'd4;
    dut_wr = 1'b1; dut_addr = BASE + 4; dut_wdata = 32'h55;
    #1;
    chk("t1_imem_addr_pc", imem_addr, 32'd4);
    chk("t1_run_wr_n", dmem_wr_n, 1'b0);
    chk("t1_run_addr", dmem_addr, BASE + 4);
    chk("t1_run_wdata", dmem_wdata, 32'h55);
    tick();
    dut_wr = 1'b0; dut_rd = 1'b1;
    #1;
    chk("t1_run_rd", dmem_rd, 1'b1);
    chk("t1_still_run", phase, 3'd2);
    dut_rd = 1'b0; dut_pc = 32'd12;
    tick();
    #1;
    chk("t1_phase_dump", phase, 3'd3);
    chk("t1_dump_dut_rst", dut_rst, 1'b1);
    chk("t1_timeout0", timeout, 1'b0);

    // Test 4: dump window with datapath requests ignored
    exp_sink[0] = 32'h1; exp_sink[1] = 32'h55; exp_sink[2] = 32'h3; exp_sink[3] = 32'h4;
    dut_wr = 1'b1; dut_addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_dmem_rd", dmem_rd, 1'b1);
      chk("t4_dmem_addr", dmem_addr, BASE + 4 * i);
      chk("t4_dmem_wr_n", dmem_wr_n, 1'b1);
      chk("t4_sink_en", sink_en, i > 0);
      if (i > 0) chk("t4_sink_data", sink_data, exp_sink[i-1]);
      tick();
    end
    dut_wr = 1'b0;
    #1;
    chk("t4_last_rd_off", dmem_rd, 1'b0);
    chk("t4_last_sink_en", sink_en, 1'b1);
    chk("t4_last_sink_data", sink_data, exp_sink[3]);
    chk("t4_last_phase", phase, 3'd3);
    tick();
    start = 1'b1;
    #1;
    chk("t4_done_phase", phase, 3'd4);
    chk("t4_done", done, 1'b1);
    chk("t4_done_sink_off", sink_en, 1'b0);
    tick(); start = 1'b0;
    #1;
    chk("t4_start_ignored", phase, 3'd4);

    // Test 2: eof on first LOAD cycle
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    stim_eof = 1'b1; stim_valid = 1'b1;
    #1;
    chk("t2_no_imem_wr", imem_wr_n, 1'b1);
    tick(); stim_eof = 1'b0; stim_valid = 1'b0;
    #1;
    chk("t2_skip_run", phase, 3'd3);
    sinks = 0;
    n = 0;
    while (!done && n < 20) begin
      if (sink_en) sinks++;
      n++;
      tick();
    end
    chk("t2_done_reached", done, 1'b1);
    chk("t2_sink_count", sinks, 4);

    // Test 3 and 6 (default build): PC stuck at 0 -> MAX_RUN timeout, no halt detection
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    stim_valid = 1'b1; stim_data = 32'h13; tick();
    stim_valid = 1'b0; stim_eof = 1'b1; tick(); stim_eof = 1'b0;
    dut_pc = 32'd0;
    n = 0;
    while (phase == 3'd2 && n < 100) begin
      if (n == 10) chk("t6_no_halt_still_run", phase, 3'd2);
      n++;
      tick();
    end
    #1;
    chk("t3_run_cycles", n, 20);
    chk("t3_phase_dump", phase, 3'd3);
    chk("t3_timeout", timeout, 1'b1);

    // Test 5: reset mid-dump, then clean restart
    tick(); tick();
    #1;
    chk("t5_pre_sink_en", sink_en, 1'b1);
    rst_n = 1'b0;
    tick();
    #1;
    chk("t5_phase_idle", phase, 3'd0);
    chk("t5_sink_en", sink_en, 1'b0);
    chk("t5_dut_rst", dut_rst, 1'b1);
    chk("t5_timeout_clr", timeout, 1'b0);
    chk("t5_dmem_rd", dmem_rd, 1'b0);
    rst_n = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    stim_valid = 1'b1; tick(); tick();
    stim_valid = 1'b0; stim_eof = 1'b1; tick(); stim_eof = 1'b0;
    dut_pc = 32'd8;
    #1;
    chk("t5_restart_run", phase, 3'd2);
    tick();
    #1;
    chk("t5_pc_end_dump", phase, 3'd3);
    chk("t5_no_timeout", timeout, 1'b0);
    sinks = 0;
    n = 0;
    while (!done && n < 20) begin
      if (sink_en) sinks++;
      n++;
      tick();
    end
    chk("t5_done", done, 1'b1);
    chk("t5_sink_count", sinks, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
